// File: rtl/bus_dev_port.sv
// Per-slot bus endpoint: a TX FIFO feeding the arbiter, and an RX FIFO that keeps only
// packets addressed to this port or to the broadcast address.
module bus_dev_port #(
    parameter int unsigned pckg_sz   = 16,
    parameter int unsigned depth     = 8,
    parameter logic [7:0]  id        = 8'h00,
    parameter logic [7:0]  broadcast = 8'hFF,
    localparam int unsigned CW       = $clog2(depth + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [pckg_sz-1:0] wr_data,
    output logic               tx_full,
    output logic [CW-1:0]      tx_count,
    output logic               tx_ovf,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    output logic               pop_err,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    output logic               rx_valid,
    output logic [pckg_sz-1:0] rd_data,
    input  logic               rd_en,
    output logic [CW-1:0]      rx_count,
    output logic [7:0]         rx_drop_cnt
);
    localparam int unsigned AW = $clog2(depth);

    logic [pckg_sz-1:0] r_tx_mem [depth];
    logic [AW-1:0]      r_tx_head;
    logic [AW-1:0]      r_tx_tail;
    logic [CW-1:0]      r_tx_count;
    logic               r_tx_ovf;
    logic               r_pop_err;

    logic [pckg_sz-1:0] r_rx_mem [depth];
    logic [AW-1:0]      r_rx_head;
    logic [AW-1:0]      r_rx_tail;
    logic [CW-1:0]      r_rx_count;
    logic [7:0]         r_rx_drop;

    logic w_tx_empty, w_tx_full, w_tx_pop, w_tx_wr;
    logic w_rx_empty, w_rx_full, w_rx_hit, w_rx_rd, w_rx_wr, w_rx_drop;
    logic [7:0] w_dest;

    // A full FIFO still accepts a write when the head is leaving in the same cycle.
    assign w_tx_empty = (r_tx_count == '0);
    assign w_tx_full  = (r_tx_count == CW'(depth));
    assign w_tx_pop   = pop && !w_tx_empty;
    assign w_tx_wr    = wr_en && (!w_tx_full || w_tx_pop);

    assign w_dest     = D_push[pckg_sz-1 -: 8];
    assign w_rx_empty = (r_rx_count == '0);
    assign w_rx_full  = (r_rx_count == CW'(depth));
    assign w_rx_hit   = push && ((w_dest == id) || (w_dest == broadcast));
    assign w_rx_rd    = rd_en && !w_rx_empty;
    assign w_rx_wr    = w_rx_hit && (!w_rx_full || w_rx_rd);
    assign w_rx_drop  = w_rx_hit && !w_rx_wr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_head  <= '0;
            r_tx_tail  <= '0;
            r_tx_count <= '0;
            r_tx_ovf   <= 1'b0;
            r_pop_err  <= 1'b0;
        end else begin
            if (w_tx_pop) r_tx_head <= r_tx_head + AW'(1);
            if (w_tx_wr)  r_tx_tail <= r_tx_tail + AW'(1);
            r_tx_count <= r_tx_count + CW'(w_tx_wr) - CW'(w_tx_pop);
            r_tx_ovf   <= wr_en && w_tx_full && !pop;
            r_pop_err  <= pop && w_tx_empty;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_head  <= '0;
            r_rx_tail  <= '0;
            r_rx_count <= '0;
            r_rx_drop  <= '0;
        end else begin
            if (w_rx_rd) r_rx_head <= r_rx_head + AW'(1);
            if (w_rx_wr) r_rx_tail <= r_rx_tail + AW'(1);
            r_rx_count <= r_rx_count + CW'(w_rx_wr) - CW'(w_rx_rd);
            if (w_rx_drop && (r_rx_drop != 8'hFF)) r_rx_drop <= r_rx_drop + 8'd1;
        end
    end

    // Storage arrays are not reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (w_tx_wr) r_tx_mem[r_tx_tail] <= wr_data;
        if (w_rx_wr) r_rx_mem[r_rx_tail] <= D_push;
    end

    assign tx_full     = w_tx_full;
    assign tx_count    = r_tx_count;
    assign tx_ovf      = r_tx_ovf;
    assign pop_err     = r_pop_err;
    assign pndng       = !w_tx_empty;
    assign D_pop       = w_tx_empty ? '0 : r_tx_mem[r_tx_head];

    assign rx_valid    = !w_rx_empty;
    assign rd_data     = w_rx_empty ? '0 : r_rx_mem[r_rx_head];
    assign rx_count    = r_rx_count;
    assign rx_drop_cnt = r_rx_drop;

endmodule

// File: doc/bus_dev_port.md
Name: bus_dev_port

Overview:
Per-device endpoint for the shared bus generator/arbiter; one instance per driver slot [bit][drvr].
- TX side: buffers host packets and presents them to the bus on pndng/D_pop; the arbiter consumes them with pop.
- RX side: accepts bus deliveries on push/D_push, filters them by destination ID (or broadcast), and queues them for the host.

Parameters:
pckg_sz, 16, packet width in bits; destination ID occupies D[pckg_sz-1 -: 8]
depth, 8, entries in each of TX and RX FIFOs (power of two, >=2)
id, 0, 8-bit device address this port answers to
broadcast, 8'hFF, destination value accepted by every port
CW, $clog2(depth+1), count width (derived localparam)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
wr_en  in  1  host write strobe into TX FIFO
wr_data  in  pckg_sz  host packet to transmit
tx_full  out  1  TX FIFO holds depth entries
tx_count  out  CW  TX occupancy
tx_ovf  out  1  one-cycle pulse: host write dropped
pndng  out  1  TX FIFO non-empty (request to arbiter)
D_pop  out  pckg_sz  TX head packet (show-ahead)
pop  in  1  arbiter consumes TX head this cycle
pop_err  out  1  one-cycle pulse: pop while empty
push  in  1  arbiter delivers a packet this cycle
D_push  in  pckg_sz  delivered packet
rx_valid  out  1  RX FIFO non-empty
rd_data  out  pckg_sz  RX head packet (show-ahead)
rd_en  in  1  host consumes RX head
rx_count  out  CW  RX occupancy
rx_drop_cnt  out  8  saturating count of accepted-but-dropped packets

Behaviour:
- Reset (reset=0, async):
  - All pointers and counts go to 0.
  - pndng=0, D_pop=0, tx_full=0, tx_ovf=0, pop_err=0.
  - rx_valid=0, rd_data=0, rx_drop_cnt=0.
  - Memory contents are don't-care.
  - Deassertion is sampled on the next clk edge.
  - Reset mid-transfer discards all queued packets in both FIFOs.
- TX FIFO:
  - Circular buffer; pointers wrap at depth.
  - D_pop = mem[head] when count>0, else 0; it is combinational from registered state.
  - pndng = (tx_count != 0), registered-state derived.
  - A write becomes visible on pndng/D_pop in the cycle after the wr_en edge, i.e. 1-cycle latency.
  - pop with count>0: head advances; the next entry appears on D_pop in the following cycle.
  - pop with count==0: ignored; pop_err=1 for one cycle.
  - wr_en while full and no pop: packet dropped, state unchanged, tx_ovf=1 for one cycle.
  - wr_en and pop in the same cycle while full: both succeed, count unchanged, no tx_ovf.
  - wr_en and pop in the same cycle while empty: write succeeds, pop_err=1, count becomes 1.
- RX filter:
  - The port accepts push when D_push[pckg_sz-1 -: 8] == id or == broadcast.
  - Other destinations are silently ignored: no counter change.
- RX FIFO:
  - An accepted push enqueues D_push.
  - rx_valid and rd_data follow the same show-ahead rules as the TX side.
  - rd_data = 0 when empty.
  - rd_en while empty: ignored.
  - Accepted push while full and no rd_en: packet dropped; rx_drop_cnt increments, saturating at 8'hFF.
  - Accepted push and rd_en in the same cycle while full: both succeed, no drop.
- TX and RX paths are fully independent; all four strobes may be active in one cycle.
- No combinational path exists from pop/push/wr_en/rd_en to any output.

Test Plan:
1. Reset held low 2 cycles, then released -> all outputs 0. Host writes 16'h01AB; next cycle pndng=1, D_pop=16'h01AB. pop for 1 cycle -> next cycle pndng=0, D_pop=0.
2. With depth=8, write 9 packets 16'h0000..16'h0008 back-to-back -> tx_full=1 after the 8th; the 9th write gives tx_ovf pulse. Pops return 0000..0007 in order, with head wrap verified by a second fill.
3. With TX full, assert wr_en(16'h0A0A) and pop in the same cycle -> tx_count stays 8, no tx_ovf, 16'h0A0A is delivered last.
4. With id=8'h02: push 16'h0255 -> accepted, rx_valid=1 next cycle, rd_data=16'h0255. Push 16'hFF11 -> accepted (broadcast). Push 16'h0311 -> ignored, rx_count unchanged.
5. Fill RX with 8 accepted pushes, then 300 more without rd_en -> rx_drop_cnt=8'hFF (saturated). Push+rd_en on a full FIFO -> no increment.
6. pop with TX empty -> pop_err one-cycle pulse, no state change. Assert reset mid-stream with 5 entries queued in both FIFOs -> counts 0 immediately (asynchronously, before the next clk edge), pndng=0, rx_valid=0.
